// File: rtl/cfg_bitstream_loader_if.sv
// Serial bitstream handshake plus configuration broadcast bus and loader status.
interface cfg_bitstream_loader_if #(
  parameter int unsigned NUM_TILES = 16,
  parameter int unsigned DATA_W    = 32
);
  logic                 bit_in;
  logic                 bit_valid;
  logic                 bit_ready;
  logic [DATA_W-1:0]    config_data;
  logic [NUM_TILES-1:0] config_en;
  logic [15:0]          frame_count;
  logic                 cfg_error;
  logic                 cfg_done;

  // Bitstream source / controller side
  modport master (
    output bit_in, bit_valid,
    input  bit_ready, config_data, config_en, frame_count, cfg_error, cfg_done
  );

  // Loader side
  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, config_data, config_en, frame_count, cfg_error, cfg_done
  );
endinterface

// File: rtl/cfg_bitstream_loader.sv
// Framed serial configuration loader: hunts for SYNC_WORD, collects an 8-bit
// tile address and a DATA_W-bit word (MSB first), then strobes the addressed tile.
module cfg_bitstream_loader #(
  parameter int unsigned NUM_TILES = 16,
  parameter int unsigned DATA_W    = 32,
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter logic [7:0]  END_ADDR  = 8'hFF
) (
  input logic                   clk,
  input logic                   reset,
  cfg_bitstream_loader_if.slave bus
);
  localparam int unsigned CNT_W      = $clog2(DATA_W);
  localparam logic [7:0]  TILE_LIMIT = 8'(NUM_TILES);

  typedef enum logic [2:0] {HUNT, ADDR, DATA, ISSUE, DONE} state_t;

  state_t            state;
  logic [7:0]        hdr;
  logic [7:0]        addr;
  logic [DATA_W-1:0] word;
  logic [CNT_W-1:0]  cnt;
  logic              take;
  logic [7:0]        hdr_next;
  logic [7:0]        addr_next;
  logic [DATA_W-1:0] word_next;

  // Shift-register next values and the bit-transfer qualifier
  always_comb begin
    take      = bus.bit_valid & bus.bit_ready;
    hdr_next  = {hdr[6:0], bus.bit_in};
    addr_next = {addr[6:0], bus.bit_in};
    word_next = {word[DATA_W-2:0], bus.bit_in};
  end

  // Frame FSM; the tile decode happens on the edge that accepts the last data
  // bit so the strobe and status are registered and visible during ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= HUNT;
      hdr             <= '0;
      addr            <= '0;
      word            <= '0;
      cnt             <= '0;
      bus.bit_ready   <= 1'b0;
      bus.config_data <= '0;
      bus.config_en   <= '0;
      bus.frame_count <= '0;
      bus.cfg_error   <= 1'b0;
      bus.cfg_done    <= 1'b0;
    end else begin
      bus.config_en <= '0;
      unique case (state)
        HUNT: begin
          bus.bit_ready <= 1'b1;
          if (take) begin
            hdr <= hdr_next;
            if (hdr_next == SYNC_WORD) begin
              state <= ADDR;
              cnt   <= '0;
            end
          end
        end
        ADDR: begin
          bus.bit_ready <= 1'b1;
          if (take) begin
            addr <= addr_next;
            if (cnt == CNT_W'(7)) begin
              cnt   <= '0;
              state <= DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DATA: begin
          bus.bit_ready <= 1'b1;
          if (take) begin
            word <= word_next;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state         <= ISSUE;
              bus.bit_ready <= 1'b0;
              if (addr < TILE_LIMIT) begin
                bus.config_data <= word_next;
                bus.config_en   <= NUM_TILES'(1) << addr;
                if (bus.frame_count != 16'hFFFF)
                  bus.frame_count <= bus.frame_count + 16'd1;
              end else if (addr == END_ADDR) begin
                bus.cfg_done <= 1'b1;
              end else begin
                bus.cfg_error <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          hdr <= '0;
          cnt <= '0;
          if (addr == END_ADDR) begin
            state         <= DONE;
            bus.bit_ready <= 1'b0;
          end else begin
            state         <= HUNT;
            bus.bit_ready <= 1'b1;
          end
        end
        DONE: begin
          bus.bit_ready <= 1'b0;
        end
        default: begin
          state         <= HUNT;
          bus.bit_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/cfg_bitstream_loader.md
Name: cfg_bitstream_loader

Overview:
- Upstream feeder for the per-tile configuration registers inside switch boxes and PEs.
- Deserialises a framed serial bitstream into 32-bit configuration words.
- Decodes the tile address and delivers each word over a shared config_data bus with a one-cycle, one-hot config_en strobe to the addressed tile.
- Tracks frame count, sticky error and end-of-load status for the top-level controller.

Parameters:
- NUM_TILES, 16, number of config_en targets; legal tile addresses 0..NUM_TILES-1, max 255.
- DATA_W, 32, configuration word width; must match the tile config register width.
- SYNC_WORD, 8'hA5, frame header pattern.
- END_ADDR, 8'hFF, address marking end of load; never a tile address.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- bit_in  input  1  serial bitstream data, MSB first.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  loader accepts a bit this cycle; a bit transfers when bit_valid & bit_ready.
- config_data  output  DATA_W  broadcast configuration word to all tiles.
- config_en  output  NUM_TILES  one-hot write strobe; bit i writes tile i.
- frame_count  output  16  number of tile frames delivered; saturates at 16'hFFFF.
- cfg_error  output  1  sticky; set on an illegal tile address.
- cfg_done  output  1  sticky; set when the END_ADDR frame completes.

Behaviour:
- All state is registered on the clk rising edge. reset is synchronous and active-high.
- Reset values: config_data=0, config_en=0, frame_count=0, cfg_error=0, cfg_done=0, bit_ready=0 in the reset cycle.
- After reset, the FSM enters HUNT with the header shift register cleared to 0.
- Reset mid-frame discards the partial frame; no config_en pulse is issued.
- FSM states:
  - HUNT: bit_ready=1. Each accepted bit shifts into an 8-bit register (new bit enters LSB). When the updated value equals SYNC_WORD, go to ADDR with the bit counter at 0. Overlapping headers are detected, e.g. the stream ...A5 immediately after a false start.
  - ADDR: bit_ready=1. Collect 8 address bits, MSB first. After the 8th accepted bit, go to DATA.
  - DATA: bit_ready=1. Collect DATA_W bits, MSB first. After the last accepted bit, go to ISSUE.
  - ISSUE: one cycle, bit_ready=0, bit_in ignored. Action depends on the address:
    - addr < NUM_TILES: drive config_data=word and config_en=(1<<addr) for exactly this cycle; frame_count+1 (saturating).
    - addr == END_ADDR: set cfg_done, config_en stays 0, go to DONE.
    - any other addr: set cfg_error, config_en stays 0, discard the frame.
    - Unless going to DONE, return to HUNT with the header register cleared.
  - DONE: bit_ready=0 and all inputs ignored until reset.
- config_data is registered and holds its last issued value after the strobe. It changes only in ISSUE cycles for legal tile addresses.
- config_en is asserted only in ISSUE, at most one bit, for one cycle.
- Cycles with bit_valid=0 stall the FSM; counters and shift registers hold.
- Latency: the config_en pulse is asserted in the cycle after the clk edge that accepts the last data bit. A legal frame with no gaps takes 8+8+DATA_W accepted bits plus one ISSUE cycle.
- Back-to-back frames: the next frame's first header bit is accepted in the cycle after ISSUE.
- Data bits that happen to equal SYNC_WORD inside ADDR or DATA are not treated as a header.
- cfg_error does not block further loading; later legal frames still issue.

Test Plan:
- Legal frame: after reset, send A5, 03, DEADBEEF with continuous valid → exactly one cycle with config_en=16'h0008 and config_data=32'hDEADBEEF, 49 cycles after the first bit; frame_count=1; config_data holds DEADBEEF afterwards.
- Hunting with noise and gaps: send garbage 0xFF 0x5A, then A5, 00, 12345678 with bit_valid randomly deasserted → config_en=16'h0001 once, config_data=32'h12345678, no spurious strobes.
- Illegal address: frame with addr 0x20 (NUM_TILES=16), data 0 → no config_en, cfg_error=1. A following legal frame to addr 5 → config_en=16'h0020, frame_count=1, cfg_error stays 1.
- End marker: two legal frames, then a frame with addr FF → cfg_done=1, frame_count=2, bit_ready=0; further valid bits produce no strobes until reset.
- Reset mid-frame: assert reset after 20 data bits → no strobe; all outputs return to reset values. A full legal frame afterwards delivers correctly.
- Embedded sync: data word 0xA5A5A5A5 to addr 1, followed immediately by a second frame to addr 2 → exactly two strobes (16'h0002, then 16'h0004) with correct data and ISSUE-cycle bit_ready=0 observed.
